// File: rtl/div5_serial_checker.sv
// Serial MSB-first divisibility-by-5 checker: folds each accepted bit into a
// mod-5 remainder and reports the result of every completed WORD_W-bit frame.
module div5_serial_checker #(
   parameter int WORD_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_valid_i,
   input  logic       bit_i,
   input  logic       start_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       div_by_5_o,
   output logic [2:0] rem_o,
   output logic       err_o,
   output logic [7:0] hit_count_o
);

   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0] W_ONE  = CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ACCUM = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_rem;
   logic [2:0]       w_rem_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_complete;
   logic             w_err;

   logic             r_done;
   logic             r_err;
   logic             r_div;
   logic [2:0]       r_rem_out;
   logic [7:0]       r_hits;

   // (2*r + b) mod 5 as a lookup over the legal remainders only.
   function automatic logic [2:0] f_rem_step(input logic [2:0] i_r, input logic i_b);
      logic [2:0] v_res;
      case ({i_r, i_b})
         4'b000_0: v_res = 3'd0;
         4'b000_1: v_res = 3'd1;
         4'b001_0: v_res = 3'd2;
         4'b001_1: v_res = 3'd3;
         4'b010_0: v_res = 3'd4;
         4'b010_1: v_res = 3'd0;
         4'b011_0: v_res = 3'd1;
         4'b011_1: v_res = 3'd2;
         4'b100_0: v_res = 3'd3;
         4'b100_1: v_res = 3'd4;
         default:  v_res = 3'd0;
      endcase
      return v_res;
   endfunction

   assign w_cnt_inc = r_cnt + W_ONE;

   // Next-state, remainder and bit-count logic.
   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_cnt_nxt   = r_cnt;
      w_complete  = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bit_valid_i) begin
               if (start_i) begin
                  w_rem_nxt = {2'b00, bit_i};
                  if (WORD_W == 1) begin
                     w_complete = 1'b1;
                     w_cnt_nxt  = '0;
                  end else begin
                     w_cnt_nxt   = W_ONE;
                     w_state_nxt = S_ACCUM;
                  end
               end else begin
                  w_err = 1'b1;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ACCUM: begin
            if (bit_valid_i) begin
               if (start_i) begin
                  // Restart discards the partial frame silently.
                  w_rem_nxt = {2'b00, bit_i};
                  w_cnt_nxt = W_ONE;
               end else begin
                  w_rem_nxt = f_rem_step(r_rem, bit_i);
                  if (w_cnt_inc == W_LAST) begin
                     w_complete  = 1'b1;
                     w_cnt_nxt   = '0;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end
            end else begin
               w_state_nxt = S_ACCUM;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_rem_nxt   = 3'd0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State, remainder and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rem   <= 3'd0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Registered result, pulse and hit-counter outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_div     <= 1'b0;
         r_rem_out <= 3'd0;
         r_hits    <= 8'd0;
      end else begin
         r_done <= w_complete;
         r_err  <= w_err;
         if (w_complete) begin
            r_rem_out <= w_rem_nxt;
            r_div     <= (w_rem_nxt == 3'd0);
            if ((w_rem_nxt == 3'd0) && (r_hits != 8'd255)) begin
               r_hits <= r_hits + 8'd1;
            end
         end
      end
   end

   assign busy_o      = (r_state == S_ACCUM);
   assign done_o      = r_done;
   assign err_o       = r_err;
   assign div_by_5_o  = r_div;
   assign rem_o       = r_rem_out;
   assign hit_count_o = r_hits;

endmodule

// File: tb/tb_div5_serial_checker.sv
// Directed self-checking bench for div5_serial_checker with WORD_W=4.
module tb_div5_serial_checker;

   logic       clk;
   logic       rst;
   logic       bit_valid_i;
   logic       bit_i;
   logic       start_i;
   logic       busy_o;
   logic       done_o;
   logic       div_by_5_o;
   logic [2:0] rem_o;
   logic       err_o;
   logic [7:0] hit_count_o;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int base;
   int ebase;
   int exp_hits;
   logic [3:0] v_val;

   div5_serial_checker #(.WORD_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .bit_valid_i (bit_valid_i),
      .bit_i       (bit_i),
      .start_i     (start_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .div_by_5_o  (div_by_5_o),
      .rem_o       (rem_o),
      .err_o       (err_o),
      .hit_count_o (hit_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && done_o) done_cnt++;
      if (!rst && err_o) err_cnt++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs; outputs are looked at 1ns after the edge.
   task automatic tick(input logic v, input logic b, input logic s);
      bit_valid_i = v;
      bit_i       = b;
      start_i     = s;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; bit_valid_i = 1'b0; bit_i = 1'b0; start_i = 1'b0;
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err",  err_o, 0);
      chk("rst_div",  div_by_5_o, 0);
      chk("rst_rem",  rem_o, 0);
      chk("rst_hits", hit_count_o, 0);
      rst = 1'b0;
      tick(1'b0, 1'b0, 1'b0);
      chk("rst_ignored_busy", busy_o, 0);

      // Frame 1010 = 10
      tick(1'b1, 1'b1, 1'b1);
      chk("f10_busy", busy_o, 1);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      chk("f10_done", done_o, 1);
      chk("f10_div",  div_by_5_o, 1);
      chk("f10_rem",  rem_o, 0);
      chk("f10_hits", hit_count_o, 1);
      chk("f10_busy_end", busy_o, 0);
      tick(1'b0, 1'b0, 1'b0);
      chk("f10_done_pulse", done_o, 0);
      chk("f10_div_hold", div_by_5_o, 1);

      // Frame 0111 = 7 with gap
      base = done_cnt;
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
      chk("f7_gap_busy", busy_o, 1);
      chk("f7_gap_done", done_o, 0);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      chk("f7_done", done_o, 1);
      chk("f7_div",  div_by_5_o, 0);
      chk("f7_rem",  rem_o, 2);
      chk("f7_hits", hit_count_o, 1);
      tick(1'b0, 1'b0, 1'b0);
      chk("f7_done_count", done_cnt - base, 1);

      // Partial 10 then restart 0101 = 5
      base = done_cnt; ebase = err_cnt;
      tick(1'b1, 1'b1, 1'b1);
      chk("ab_busy0", busy_o, 1);
      tick(1'b1, 1'b0, 1'b0);
      chk("ab_busy1", busy_o, 1);
      tick(1'b1, 1'b0, 1'b1);
      chk("ab_busy2", busy_o, 1);
      chk("ab_no_done", done_o, 0);
      tick(1'b1, 1'b1, 1'b0);
      chk("ab_busy3", busy_o, 1);
      tick(1'b1, 1'b0, 1'b0);
      chk("ab_busy4", busy_o, 1);
      tick(1'b1, 1'b1, 1'b0);
      chk("f5_done", done_o, 1);
      chk("f5_div",  div_by_5_o, 1);
      chk("f5_rem",  rem_o, 0);
      chk("f5_hits", hit_count_o, 2);
      tick(1'b0, 1'b0, 1'b0);
      chk("ab_done_count", done_cnt - base, 1);
      chk("ab_err_count", err_cnt - ebase, 0);

      // Stray bit while idle
      tick(1'b1, 1'b1, 1'b0);
      chk("err_pulse", err_o, 1);
      chk("err_busy",  busy_o, 0);
      chk("err_rem",   rem_o, 0);
      chk("err_div",   div_by_5_o, 1);
      chk("err_hits",  hit_count_o, 2);
      tick(1'b0, 1'b0, 1'b0);
      chk("err_one_cycle", err_o, 0);

      // All 16 values back-to-back
      exp_hits = 2;
      for (int v = 0; v < 16; v++) begin
         v_val = 4'(v);
         for (int k = 3; k >= 0; k--) tick(1'b1, v_val[k], (k == 3));
         if ((v % 5) == 0) exp_hits++;
         chk($sformatf("ex_done_%0d", v), done_o, 1);
         chk($sformatf("ex_rem_%0d", v), rem_o, v % 5);
         chk($sformatf("ex_div_%0d", v), div_by_5_o, ((v % 5) == 0) ? 1 : 0);
      end
      chk("ex_hits", hit_count_o, exp_hits);
      tick(1'b0, 1'b0, 1'b0);

      // Saturation with 260 frames of 1111
      for (int f = 0; f < 260; f++) begin
         for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, (k == 0));
      end
      chk("sat_hits", hit_count_o, 255);
      chk("sat_rem", rem_o, 0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
      chk("sat_hold", hit_count_o, 255);

      // Reset mid-frame
      base = done_cnt;
      tick(1'b1, 1'b1, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      bit_valid_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("mrst_busy", busy_o, 0);
      chk("mrst_hits", hit_count_o, 0);
      chk("mrst_rem",  rem_o, 0);
      chk("mrst_div",  div_by_5_o, 0);
      tick(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      chk("mrst_no_done", done_cnt - base, 0);
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      chk("f0_done", done_o, 1);
      chk("f0_div",  div_by_5_o, 1);
      chk("f0_rem",  rem_o, 0);
      chk("f0_hits", hit_count_o, 1);
      tick(1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
